uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port serial_in  input  1  UART line; idle high; 8N1 frames, LSB first.
REQ-006 SHALL have port data_out  output  8  received byte.
REQ-007 SHALL have port data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready  input  1  consumer accepts data_out.
REQ-009 SHALL have port overrun  output  1  sticky flag; a completed byte was dropped.

Function
REQ-010 SHALL derive SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division) and SAMPLE_TIME = SYMBOL_EDGE_TIME/2, with a cycle counter sized by clog2(SYMBOL_EDGE_TIME).
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 IDLE: a low sample of the line (after optional synchronizer) SHALL move to START with the counter cleared.
REQ-013 START: at count SAMPLE_TIME-1, line high SHALL return to IDLE (false start); line low SHALL move to DATA with the counter restarted.
REQ-014 DATA: SHALL sample one bit every SYMBOL_EDGE_TIME cycles into a shift register, LSB first, and move to STOP after bit 7.
REQ-015 STOP: one SYMBOL_EDGE_TIME after bit 7, line high SHALL complete the frame; line low (framing error) SHALL discard the byte; either way SHALL return to IDLE.
REQ-016 On completion with data_out_valid=0, data_out SHALL load the byte and data_out_valid SHALL assert on the next edge.
REQ-017 A transfer occurs when data_out_valid && data_out_ready at a rising edge; data_out_valid SHALL deassert the following cycle unless REQ-019 applies.
REQ-018 While data_out_valid=1 and data_out_ready=0, data_out SHALL remain stable.
REQ-019 Completion in the same cycle as a transfer SHALL load the new byte, keep data_out_valid=1, and SHALL NOT set overrun.
REQ-020 Completion with data_out_valid=1 and no transfer SHALL drop the new byte, keep the old byte, and set overrun (cleared only by reset).
REQ-021 Reception SHALL continue regardless of data_out_valid; back-to-back frames SHALL be received with no idle gap required.

Reset
REQ-022 rst low SHALL immediately force state IDLE, counter 0, shift register 0, data_out 8'h00, data_out_valid 0, overrun 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; the first frame after reset release SHALL require a new falling edge.

Configuration
REQ-024 With UART_RX_SYNC_EN defined, serial_in SHALL pass through a 2-flop synchronizer (reset value 1), adding exactly 2 cycles of detection latency.
REQ-025 Without UART_RX_SYNC_EN, serial_in SHALL drive the state machine directly with no synchronizer flops.

Structure
REQ-026 State encoding and the SYMBOL_EDGE_TIME/SAMPLE_TIME expressions SHALL live in shared package uart_pkg for reuse by the transmitter.
REQ-027 The synchronizer SHALL be a sub-module named synchronizer (parameter WIDTH=1), instantiated only under UART_RX_SYNC_EN.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=115_200: SYMBOL_EDGE_TIME=434, SAMPLE_TIME=217)
REQ-028 Frame 0xA5, data_out_ready=1 -> data_out=8'hA5, data_out_valid high exactly 1 cycle, overrun=0.
REQ-029 Low glitch of 100 cycles in IDLE -> return to IDLE, no data_out_valid.
REQ-030 Frames 0x12 then 0x34 back-to-back, data_out_ready=0 -> data_out stays 8'h12, data_out_valid=1, overrun=1.
REQ-031 Frame 0x55 with stop bit low -> no data_out_valid; following frame 0x0F received correctly.
REQ-032 rst low at bit 4 of frame 0xFF -> all outputs 0 immediately; next full frame 0x3C received as 8'h3C.
REQ-033 data_out_ready pulsed in the same cycle a second frame 0x77 completes -> data_out=8'h77, data_out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding and the
//                bit-timing expressions shared by receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per serial symbol (integer division)
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from a falling edge to the middle of the start bit
    function automatic int sample_time(input int symbol_cycles);
        return symbol_cycles / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : synchronizer
//  Description : Two-flop metastability synchronizer. Flops reset to all-ones
//                so an idle-high serial line does not look like a start bit
//                while the chain refills after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module synchronizer
    import uart_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
        end
    end

    assign o_data = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver with a single-entry valid/ready output
//                register and a sticky overrun flag. Bits are sampled at the
//                middle of each symbol, timed from the start-bit falling edge.
//                Optional build macro UART_RX_SYNC_EN inserts a 2-flop input
//                synchronizer (2 extra cycles of detection latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(SYMBOL_EDGE_TIME);
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

    localparam logic [CNT_W-1:0] c_symbol_last = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] c_sample_last = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic w_line;

`ifdef UART_RX_SYNC_EN
    synchronizer #(
        .WIDTH (1)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_data (serial_in),
        .o_data (w_line)
    );
`else
    assign w_line = serial_in;
`endif

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_frame_done;

    // State, counter and shift-register storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic: mid-start check, mid-bit sampling, mid-stop check
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_frame_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_line) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end

            START: begin
                if (r_cnt == c_sample_last) begin
                    // Line back high by mid-start means it was only a glitch
                    w_state_nxt   = w_line ? IDLE : DATA;
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            DATA: begin
                if (r_cnt == c_symbol_last) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_line, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            STOP: begin
                if (r_cnt == c_symbol_last) begin
                    // A low stop bit is a framing error: byte is discarded
                    w_frame_done = w_line;
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output holding register and overrun flag
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 w_xfer;

    assign w_xfer = r_valid && data_out_ready;

    // Load on completion if empty or draining this cycle; otherwise drop and flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_done && (!r_valid || w_xfer)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else begin
                if (w_xfer) begin
                    r_valid <= 1'b0;
                end
                if (w_frame_done) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Scoreboard bench for uart_receiver. A transaction-level model
//                (single-entry output buffer, drop-and-flag when full) predicts
//                delivered bytes at stimulus time; a monitor pops and compares
//                on every accepted output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CLOCK_FREQ  = 50_000_000;
    localparam int BAUD_RATE   = 115_200;
    localparam int BIT_CYC     = CLOCK_FREQ / BAUD_RATE;    // 434
    localparam int HALF_CYC    = BIT_CYC / 2;               // 217
    // Edges from start-bit detection to the mid-stop-bit sample
    localparam int DONE_OFFSET = HALF_CYC + 9 * BIT_CYC;

    logic       clk            = 1'b0;
    logic       rst            = 1'b0;
    logic       serial_in      = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       overrun;

    uart_receiver #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int         n_checks     = 0;
    int         n_fail       = 0;
    int         valid_cycles = 0;
    int         vc0          = 0;
    logic [7:0] exp_q[$];
    logic       model_overrun = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] rb;
    logic       rok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one-deep output buffer; a completed byte is kept if the
    // buffer is empty or being drained at that moment, otherwise dropped.
    function automatic void predict(input logic [7:0] b, input logic stop_ok,
                                    input logic ready_at_done);
        if (stop_ok) begin
            if (exp_q.size() == 0 || ready_at_done) begin
                exp_q.push_back(b);
            end else begin
                model_overrun = 1'b1;
            end
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input logic ready_at_done);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        predict(b, stop_ok, ready_at_done);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            serial_in = bits[i];
            repeat (BIT_CYC - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3 * BIT_CYC) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: samples mid-low-phase; a byte is taken when valid && ready
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && data_out_valid) begin
                valid_cycles++;
                if (data_out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected no byte", data_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("data_out", data_out, mon_exp);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (98_000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got timeout, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame, consumer always ready
        data_out_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_drain("a5");
        check("a5_valid_cycles", valid_cycles - vc0, 1);
        check("a5_overrun", overrun, model_overrun);

        // Short low glitch while idle
        vc0 = valid_cycles;
        @(negedge clk);
        serial_in = 1'b0;
        repeat (99) @(negedge clk);
        idle(10 * BIT_CYC);
        check("glitch_no_valid", valid_cycles - vc0, 0);

        // Back-to-back frames with consumer stalled
        data_out_ready = 1'b0;
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(20);
        check("ovr_data_out", data_out, 8'h12);
        check("ovr_valid", data_out_valid, 1'b1);
        check("ovr_overrun", overrun, model_overrun);
        data_out_ready = 1'b1;
        wait_drain("ovr");
        repeat (5) @(negedge clk);
        check("ovr_sticky", overrun, model_overrun);

        // Framing error, then a good frame
        vc0 = valid_cycles;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(2 * BIT_CYC);
        check("ferr_no_valid", valid_cycles - vc0, 0);
        send_frame(8'h0F, 1'b1, 1'b1);
        wait_drain("ferr");

        // Reset in the middle of bit 4 of 0xFF
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BIT_CYC - 1) @(negedge clk);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (4 * BIT_CYC + HALF_CYC) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_data_out", data_out, 8'h00);
        check("mid_rst_valid", data_out_valid, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        exp_q.delete();
        model_overrun = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_drain("after_rst");
        check("after_rst_overrun", overrun, model_overrun);

        // Ready pulsed exactly when the second frame completes
        data_out_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        fork
            send_frame(8'h77, 1'b1, 1'b1);
            begin
                @(negedge clk);
                repeat (DONE_OFFSET) @(negedge clk);
                data_out_ready = 1'b1;
                @(negedge clk);
                data_out_ready = 1'b0;
            end
        join
        check("same_cycle_data_out", data_out, 8'h77);
        check("same_cycle_valid", data_out_valid, 1'b1);
        check("same_cycle_overrun", overrun, model_overrun);
        data_out_ready = 1'b1;
        wait_drain("same_cycle");

        // Randomized frames, occasional framing errors
        for (int k = 0; k < 5; k++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 4) != 0);
            send_frame(rb, rok, 1'b1);
            if (!rok) idle(2 * BIT_CYC);
            else      idle($urandom_range(1, 40));
        end
        wait_drain("rand");
        check("rand_overrun", overrun, model_overrun);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
